// File: rtl/lut_remap_engine.sv
// Double-buffered LUT remap engine: lookups read the active bank, cfg writes the shadow bank,
// and a commit swaps banks, then re-syncs the new shadow from the new active one LUT per cycle.
// Optional macro LUT_REMAP_BCAST_EN adds cfg_bcast (write one image to every shadow LUT).
module lut_remap_engine #(
  parameter int NUM_LUTS  = 16,
  parameter int LUT_DEPTH = 16,
  parameter int LUT_WIDTH = 4,
  parameter int LANES     = 1024,
  localparam int IDX_W    = $clog2(LUT_DEPTH),
  localparam int LID_W    = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1,
  localparam int DATA_W   = LUT_DEPTH * LUT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic                       cfg_commit,
  input  logic [LID_W-1:0]           cfg_lut_id,
  input  logic [DATA_W-1:0]          cfg_data,
`ifdef LUT_REMAP_BCAST_EN
  input  logic                       cfg_bcast,
`endif
  output logic                       cfg_err,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*IDX_W-1:0]     in_idx,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*LUT_WIDTH-1:0] out_data,
  output logic                       active_bank,
  output logic                       dbg_state
);

  localparam int LANES_PER_LUT = LANES / NUM_LUTS;
  localparam logic [LID_W:0]   NUM_LUTS_W = (LID_W+1)'(NUM_LUTS);
  localparam logic [LID_W-1:0] LAST_LUT   = LID_W'(NUM_LUTS - 1);

  // Handshakes: a beat transfers on a rising clk edge where valid and ready are both 1;
  // a valid source holds its payload until that edge, and ready never depends on valid.

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_COPY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [LID_W-1:0]     copy_idx_q;
  logic [DATA_W-1:0]    bank_q [2][NUM_LUTS];
  logic                 active_q;
  logic                 shadow;
  logic                 cfg_fire, commit_fire, write_fire, id_ok, copy_last, in_fire;
  logic [LANES*LUT_WIDTH-1:0] lookup_data;

  assign shadow      = ~active_q;
  assign cfg_ready   = (state_q == ST_IDLE);
  assign cfg_fire    = cfg_valid && cfg_ready;
  assign commit_fire = cfg_fire && cfg_commit;
  assign write_fire  = cfg_fire && !cfg_commit;
  assign id_ok       = ({1'b0, cfg_lut_id} < NUM_LUTS_W);
  assign copy_last   = (copy_idx_q == LAST_LUT);
  assign in_ready    = !out_valid || out_ready;
  assign in_fire     = in_valid && in_ready;
  assign active_bank = active_q;
  assign dbg_state   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      copy_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_COPY) begin
        copy_idx_q <= copy_last ? '0 : copy_idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (commit_fire) state_d = ST_COPY;
      ST_COPY: if (copy_last)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // cfg is blocked during COPY, so shadow writes and the copy never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int l = 0; l < NUM_LUTS; l++) begin
          bank_q[b][l] <= '0;
        end
      end
      active_q <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      if (commit_fire) begin
        active_q <= ~active_q;
      end
      if (write_fire) begin
`ifdef LUT_REMAP_BCAST_EN
        if (cfg_bcast) begin
          for (int l = 0; l < NUM_LUTS; l++) begin
            bank_q[shadow][l] <= cfg_data;
          end
        end else
`endif
        if (id_ok) begin
          bank_q[shadow][cfg_lut_id] <= cfg_data;
        end else begin
          cfg_err <= 1'b1;
        end
      end
      if (state_q == ST_COPY) begin
        bank_q[shadow][copy_idx_q] <= bank_q[active_q][copy_idx_q];
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [IDX_W-1:0]  lane_idx;
    logic [DATA_W-1:0] lane_word;
    assign lane_idx  = in_idx[k*IDX_W +: IDX_W];
    assign lane_word = bank_q[active_q][k / LANES_PER_LUT];
    assign lookup_data[k*LUT_WIDTH +: LUT_WIDTH] = lane_word[lane_idx*LUT_WIDTH +: LUT_WIDTH];
  end

  // Result register samples the pre-edge bank, so a same-edge commit does not affect it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_data  <= lookup_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lut_remap_engine.sv
// Directed bench for lut_remap_engine: default instance plus NUM_LUTS=12 and NUM_LUTS=32 instances.
// Build with LUT_REMAP_BCAST_EN defined to add the broadcast steps.
module tb_lut_remap_engine;

  localparam int NUM_LUTS  = 16;
  localparam int LUT_DEPTH = 16;
  localparam int LUT_WIDTH = 4;
  localparam int LANES     = 1024;
  localparam int IDX_W     = 4;
  localparam int LID_W     = 4;
  localparam int DATA_W    = LUT_DEPTH * LUT_WIDTH;
  localparam int IN_W      = LANES * IDX_W;
  localparam int OUT_W     = LANES * LUT_WIDTH;
  localparam int PER       = LANES / NUM_LUTS;

  localparam logic [DATA_W-1:0] IMG_REV = 64'h0123456789ABCDEF;  // entry j = 15-j
  localparam logic [DATA_W-1:0] IMG_ID  = 64'hFEDCBA9876543210;  // entry j = j

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic              cfg_valid, cfg_ready, cfg_commit, cfg_err;
  logic [LID_W-1:0]  cfg_lut_id;
  logic [DATA_W-1:0] cfg_data;
  logic              in_valid, in_ready, out_valid, out_ready, active_bank, dbg_state;
  logic [IN_W-1:0]   in_idx;
  logic [OUT_W-1:0]  out_data;
`ifdef LUT_REMAP_BCAST_EN
  logic              cfg_bcast;
`endif

  // NUM_LUTS=12 instance
  logic              c_cfg_valid, c_cfg_ready, c_cfg_commit, c_cfg_err;
  logic [3:0]        c_cfg_lut_id;
  logic [DATA_W-1:0] c_cfg_data;
  logic              c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_active_bank, c_dbg_state;
  logic [47:0]       c_in_idx;
  logic [47:0]       c_out_data;

  // NUM_LUTS=32 instance
  logic              d_cfg_valid, d_cfg_ready, d_cfg_commit, d_cfg_err;
  logic [4:0]        d_cfg_lut_id;
  logic [DATA_W-1:0] d_cfg_data;
  logic              d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_active_bank, d_dbg_state;
  logic [127:0]      d_in_idx;
  logic [127:0]      d_out_data;

  lut_remap_engine #(.NUM_LUTS(NUM_LUTS), .LUT_DEPTH(LUT_DEPTH), .LUT_WIDTH(LUT_WIDTH), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_commit(cfg_commit),
    .cfg_lut_id(cfg_lut_id), .cfg_data(cfg_data),
`ifdef LUT_REMAP_BCAST_EN
    .cfg_bcast(cfg_bcast),
`endif
    .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .active_bank(active_bank), .dbg_state(dbg_state)
  );

  lut_remap_engine #(.NUM_LUTS(12), .LUT_DEPTH(16), .LUT_WIDTH(4), .LANES(12)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(c_cfg_valid), .cfg_ready(c_cfg_ready), .cfg_commit(c_cfg_commit),
    .cfg_lut_id(c_cfg_lut_id), .cfg_data(c_cfg_data),
`ifdef LUT_REMAP_BCAST_EN
    .cfg_bcast(1'b0),
`endif
    .cfg_err(c_cfg_err), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_idx(c_in_idx),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .active_bank(c_active_bank), .dbg_state(c_dbg_state)
  );

  lut_remap_engine #(.NUM_LUTS(32), .LUT_DEPTH(16), .LUT_WIDTH(4), .LANES(32)) dut_d (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(d_cfg_valid), .cfg_ready(d_cfg_ready), .cfg_commit(d_cfg_commit),
    .cfg_lut_id(d_cfg_lut_id), .cfg_data(d_cfg_data),
`ifdef LUT_REMAP_BCAST_EN
    .cfg_bcast(1'b0),
`endif
    .cfg_err(d_cfg_err), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_idx(d_in_idx),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
    .active_bank(d_active_bank), .dbg_state(d_dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] model_active [NUM_LUTS];
  logic [DATA_W-1:0] model_shadow [NUM_LUTS];
  logic [OUT_W-1:0]  exp_v;
  int                copy_cycles;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    int lane;
    lane = 0;
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      for (int k = LANES - 1; k >= 0; k--) begin
        if (obs[k*4 +: 4] !== exp[k*4 +: 4]) lane = k;
      end
      $error("FAIL %s: lane %0d observed %0h expected %0h", tag, lane, obs[lane*4 +: 4], exp[lane*4 +: 4]);
    end
  endtask

  function automatic logic [OUT_W-1:0] model_out(input logic [IDX_W-1:0] v);
    logic [OUT_W-1:0]  r;
    logic [DATA_W-1:0] w;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      w = model_active[k / PER];
      r[k*4 +: 4] = w[v*4 +: 4];
    end
    return r;
  endfunction

  task automatic fill_idx(input logic [IDX_W-1:0] v);
    for (int k = 0; k < LANES; k++) in_idx[k*IDX_W +: IDX_W] = v;
  endtask

  task automatic model_clear();
    for (int l = 0; l < NUM_LUTS; l++) begin
      model_active[l] = '0;
      model_shadow[l] = '0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!cfg_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check32({tag, "_idle"}, 32'(cfg_ready), 32'd1);
  endtask

  task automatic cfg_write(input logic [LID_W-1:0] id, input logic [DATA_W-1:0] d, input logic bc);
    wait_idle("wr");
    cfg_valid = 1'b1; cfg_commit = 1'b0; cfg_lut_id = id; cfg_data = d;
`ifdef LUT_REMAP_BCAST_EN
    cfg_bcast = bc;
`endif
    @(negedge clk);
    cfg_valid = 1'b0;
`ifdef LUT_REMAP_BCAST_EN
    cfg_bcast = 1'b0;
`endif
    if (bc) begin
      for (int l = 0; l < NUM_LUTS; l++) model_shadow[l] = d;
    end else begin
      model_shadow[id] = d;
    end
  endtask

  task automatic do_commit();
    wait_idle("cm");
    cfg_valid = 1'b1; cfg_commit = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; cfg_commit = 1'b0;
    for (int l = 0; l < NUM_LUTS; l++) model_active[l] = model_shadow[l];
  endtask

  task automatic lookup(input string tag, input logic [IDX_W-1:0] v);
    fill_idx(v); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check32({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_vec(tag, out_data, model_out(v));
    @(negedge clk);
  endtask

  initial begin
    cfg_valid = 0; cfg_commit = 0; cfg_lut_id = '0; cfg_data = '0;
    in_valid = 0; in_idx = '0; out_ready = 1;
`ifdef LUT_REMAP_BCAST_EN
    cfg_bcast = 0;
`endif
    c_cfg_valid = 0; c_cfg_commit = 0; c_cfg_lut_id = '0; c_cfg_data = '0;
    c_in_valid = 0; c_in_idx = '0; c_out_ready = 1;
    d_cfg_valid = 0; d_cfg_commit = 0; d_cfg_lut_id = '0; d_cfg_data = '0;
    d_in_valid = 0; d_in_idx = '0; d_out_ready = 1;
    model_clear();

    // clock/reset
    rst_n = 0;
    repeat (3) @(negedge clk);
    check32("rst_out_valid", 32'(out_valid), 32'd0);
    check_vec("rst_out_data", out_data, '0);
    check32("rst_active_bank", 32'(active_bank), 32'd0);
    check32("rst_cfg_err", 32'(cfg_err), 32'd0);
    check32("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    rst_n = 1;
    @(negedge clk);

    // lookup on cleared banks, one-cycle latency
    fill_idx(4'd5); in_valid = 1; out_ready = 1;
    check32("lat_before", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 0;
    check32("lat_after", 32'(out_valid), 32'd1);
    check_vec("zero_lookup", out_data, '0);
    @(negedge clk);
    check32("drain_valid", 32'(out_valid), 32'd0);

    // shadow write is invisible until commit
    cfg_write(4'd0, IMG_REV, 1'b0);
    lookup("pre_commit", 4'd3);
    do_commit();
    check32("commit_bank", 32'(active_bank), 32'd1);
    check32("commit_state", 32'(dbg_state), 32'd1);

    // held write during COPY: blocked for exactly NUM_LUTS cycles
    cfg_valid = 1; cfg_commit = 0; cfg_lut_id = 4'd1; cfg_data = IMG_ID;
    copy_cycles = 0;
    while (!cfg_ready && copy_cycles < 100) begin
      @(negedge clk);
      copy_cycles++;
    end
    check32("copy_cycles", 32'(copy_cycles), 32'd16);
    @(negedge clk);
    cfg_valid = 0;
    model_shadow[1] = IMG_ID;
    exp_v = '0;
    for (int k = 0; k < 64; k++) exp_v[k*4 +: 4] = 4'd12;
    check_vec("lut0_idx3_hand", model_out(4'd3), exp_v);
    lookup("post_commit", 4'd3);

    do_commit();
    check32("commit2_bank", 32'(active_bank), 32'd0);
    wait_idle("c2");
    for (int k = 64; k < 128; k++) exp_v[k*4 +: 4] = 4'd3;
    fill_idx(4'd3); in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    check_vec("copy_persist", out_data, exp_v);
    @(negedge clk);

    // output stall and release
    fill_idx(4'd1); in_valid = 1; out_ready = 1;
    @(negedge clk);
    check32("stall_v0", 32'(out_valid), 32'd1);
    check_vec("stall_d0", out_data, model_out(4'd1));
    fill_idx(4'd2); out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check32("stall_in_ready", 32'(in_ready), 32'd0);
      check_vec("stall_hold", out_data, model_out(4'd1));
    end
    out_ready = 1;
    @(negedge clk);
    check_vec("stream_b2", out_data, model_out(4'd2));
    fill_idx(4'd3);
    @(negedge clk);
    check32("stream_ready", 32'(in_ready), 32'd1);
    check_vec("stream_b3", out_data, model_out(4'd3));
    fill_idx(4'd4);
    @(negedge clk);
    check_vec("stream_b4", out_data, model_out(4'd4));
    in_valid = 0;
    @(negedge clk);
    check32("stream_end", 32'(out_valid), 32'd0);

    // highest id is valid for NUM_LUTS=16
    cfg_write(4'd15, IMG_REV, 1'b0);
    check32("id15_err", 32'(cfg_err), 32'd0);

    // commit and lookup on the same edge: lookup sees the pre-commit bank
    wait_idle("cl");
    exp_v = model_out(4'd5);
    fill_idx(4'd5); in_valid = 1; cfg_valid = 1; cfg_commit = 1;
    @(negedge clk);
    in_valid = 0; cfg_valid = 0; cfg_commit = 0;
    for (int l = 0; l < NUM_LUTS; l++) model_active[l] = model_shadow[l];
    check_vec("commit_same_edge", out_data, exp_v);
    @(negedge clk);
    wait_idle("cl2");
    lookup("after_commit15", 4'd5);

    // write and lookup on the same edge
    exp_v = model_out(4'd4);
    cfg_valid = 1; cfg_commit = 0; cfg_lut_id = 4'd2; cfg_data = IMG_REV;
    fill_idx(4'd4); in_valid = 1;
    @(negedge clk);
    cfg_valid = 0; in_valid = 0;
    model_shadow[2] = IMG_REV;
    check_vec("write_same_edge", out_data, exp_v);
    @(negedge clk);

    // NUM_LUTS=12: id 13 flags an error and leaves banks untouched
    check32("c_rst_err", 32'(c_cfg_err), 32'd0);
    c_cfg_valid = 1; c_cfg_lut_id = 4'd13; c_cfg_data = IMG_ID;
    @(negedge clk);
    c_cfg_valid = 0;
    check32("c_err_set", 32'(c_cfg_err), 32'd1);
    c_cfg_valid = 1; c_cfg_commit = 1;
    @(negedge clk);
    c_cfg_valid = 0; c_cfg_commit = 0;
    repeat (14) @(negedge clk);
    check32("c_idle", 32'(c_cfg_ready), 32'd1);
    c_in_idx = {12{4'h9}}; c_in_valid = 1;
    @(negedge clk);
    c_in_valid = 0;
    check32("c_banks_unchanged", c_out_data[31:0], 32'd0);
    check32("c_banks_unchanged_hi", 32'(c_out_data[47:32]), 32'd0);
    check32("c_err_sticky", 32'(c_cfg_err), 32'd1);

    // NUM_LUTS=32: id 16 is a normal write
    d_cfg_valid = 1; d_cfg_lut_id = 5'd16; d_cfg_data = IMG_ID;
    @(negedge clk);
    d_cfg_valid = 0;
    check32("d_id16_err", 32'(d_cfg_err), 32'd0);
    d_cfg_valid = 1; d_cfg_commit = 1;
    @(negedge clk);
    d_cfg_valid = 0; d_cfg_commit = 0;
    repeat (34) @(negedge clk);
    check32("d_idle", 32'(d_cfg_ready), 32'd1);
    d_in_idx = {32{4'h6}}; d_in_valid = 1;
    @(negedge clk);
    d_in_valid = 0;
    check32("d_lane16", 32'(d_out_data[67:64]), 32'd6);
    check32("d_lanes_lo", d_out_data[31:0], 32'd0);
    check32("d_lanes_hi", d_out_data[127:96], 32'd0);

`ifdef LUT_REMAP_BCAST_EN
    // broadcast identity image: every lane returns its own index
    cfg_write(4'd3, IMG_ID, 1'b1);
    check32("bcast_err", 32'(cfg_err), 32'd0);
    do_commit();
    wait_idle("bc");
    for (int k = 0; k < LANES; k++) begin
      in_idx[k*IDX_W +: IDX_W] = IDX_W'(k % 16);
      exp_v[k*4 +: 4] = 4'(k % 16);
    end
    in_valid = 1; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    check_vec("bcast_lanes", out_data, exp_v);
    @(negedge clk);
`endif

    // reset mid-COPY with a stalled output
    do_commit();
    repeat (3) @(negedge clk);
    fill_idx(4'd2); in_valid = 1; out_ready = 0;
    @(negedge clk);
    check32("pre_rst_stall", 32'(out_valid), 32'd1);
    check32("pre_rst_copy", 32'(cfg_ready), 32'd0);
    rst_n = 0;
    #1;
    check32("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_vec("mid_rst_out_data", out_data, '0);
    check32("mid_rst_bank", 32'(active_bank), 32'd0);
    check32("mid_rst_ready", 32'(cfg_ready), 32'd1);
    check32("mid_rst_state", 32'(dbg_state), 32'd0);
    check32("mid_rst_c_err", 32'(c_cfg_err), 32'd0);
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    rst_n = 1;
    model_clear();
    @(negedge clk);
    lookup("post_rst", 4'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
